mod_counter: RTL

Parametrised modulo up/down counter, the next-generation replacement for the fixed 4-bit free-running lab counter. It adds configurable width and modulus, direction control, count enable, synchronous parallel load, synchronous reset and a terminal-count pulse. It sits in lab designs as a timebase, digit counter or cascadable counter stage: chain stages by feeding one stage's `tc` into the next stage's `en`. An optional prescaler, compiled in by macro, divides the count rate.

---
 rtl/counter_pkg.sv | 27 ++
 rtl/tick_prescaler.sv | 29 ++
 rtl/mod_counter.sv | 86 ++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter family: direction encodings,
// a constant clog2 for register sizing and parameter-legality checks.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // True when the counter parameters describe a buildable counter.
  function automatic bit params_legal(input int width, input int modulo,
                                      input int reset_val, input int prescale);
    bit ok;
    ok = (width >= 1) && (width < 31);
    ok = ok && (modulo >= 2) && (modulo <= (1 << width));
    ok = ok && (reset_val >= 0) && (reset_val < modulo);
    ok = ok && (prescale >= 1);
    return ok;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Rate divider: tick is high on every PRESCALE-th enabled cycle, counting
// from zero after rst or clr.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  // A zero-width register is not legal, so PRESCALE = 1 keeps one bit that never leaves 0.
  localparam int CW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Advance only on enabled cycles, restarting after the last one.
  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (en)     cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo up/down counter with load, enable and a one-cycle
// terminal-count pulse. Chain stages by feeding tc into the next en.
// Optional prescaler compiled in with `define MOD_COUNTER_PRESCALE_EN.
module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULO    = 16,
  parameter int RESET_VAL = 0,
  parameter int PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] o,
  output logic             tc,
  output logic             zero
);

  if (!params_legal(WIDTH, MODULO, RESET_VAL, PRESCALE)) begin : g_bad_params
    $error("mod_counter: illegal WIDTH/MODULO/RESET_VAL/PRESCALE combination");
  end

  localparam logic [WIDTH-1:0] MAX     = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);

  logic             tick;
  logic             step;
  logic [WIDTH-1:0] load_val;

`ifdef MOD_COUNTER_PRESCALE_EN
  tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .en   (en),
    .tick (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign step = en & tick;

  // Out-of-range load values clamp to the top of the count range; the
  // extra bit keeps the compare correct when MODULO = 2^WIDTH.
  assign load_val = ({1'b0, din} < MOD_EXT) ? din : MAX;

  assign zero = (o == '0);

  // Count register and tc: rst beats load beats step; tc only on a wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      o  <= RST_V;
      tc <= 1'b0;
    end else if (load) begin
      o  <= load_val;
      tc <= 1'b0;
    end else if (step) begin
      if (up == DIR_UP) begin
        if (o == MAX) begin
          o  <= '0;
          tc <= 1'b1;
        end else begin
          o  <= o + 1'b1;
          tc <= 1'b0;
        end
      end else begin
        if (o == '0) begin
          o  <= MAX;
          tc <= 1'b1;
        end else begin
          o  <= o - 1'b1;
          tc <= 1'b0;
        end
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule
